// File: rtl/grid_frame_sequencer.sv
// -----------------------------------------------------------------------------
// grid_frame_sequencer
//
// Walks the combinational snake/food grid mapper one row at a time and captures
// each 16-bit column pattern into the back half of a double-buffered 16x16
// frame store. When the last row has been captured, the buffers swap in a
// single cycle. The LED-matrix driver therefore only ever sees complete frames.
//
// Parameters
//   ROWS    rows scanned per frame (1..16); rows >= ROWS are never written
//   SETTLE  wait cycles after grid_row changes before grid_col is used (>= 1)
//
// Ports
//   clk        system clock
//   reset_n    synchronous active-low reset
//   start      single-cycle request to build a new frame
//   busy       high while a frame build is in progress (SETTLE/CAPTURE/SWAP)
//   done       one-cycle pulse in the cycle the new frame becomes visible
//   grid_row   row index driven to the mapper (zero-extended 4-bit counter)
//   grid_col   mapper result for grid_row, bit 15 = column 0
//   disp_row   row requested by the display driver
//   disp_col   registered front-buffer contents of disp_row (1-cycle latency)
//   dbg_state  current FSM state, for checkers and debug
//
// Handshake: start is a fire-and-forget pulse with no ready. A start that
// arrives while busy (including the SWAP cycle) is remembered in a 1-deep
// pending flag; further starts merge into that flag. done marks the frame
// boundary; busy stays high across back-to-back frames.
// -----------------------------------------------------------------------------
module grid_frame_sequencer #(
  parameter int ROWS   = 16,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] grid_row,
  input  logic [15:0] grid_col,
  input  logic [3:0]  disp_row,
  output logic [15:0] disp_col,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_SWAP    = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROW    = 4'(ROWS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  settle_q, settle_d;
  logic        front_q, front_d;
  logic        pending_q, pending_d;
  logic        wr_en;
  logic [15:0] frame_q [2][16];
  logic [15:0] disp_col_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    settle_d  = settle_q;
    front_d   = front_q;
    pending_d = pending_q;
    wr_en     = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // pending can only be set here if a start landed in the SWAP cycle
        // of a frame that had nothing else queued; honour it now.
        if (start || pending_q) begin
          row_d     = 4'd0;
          settle_d  = 8'd0;
          pending_d = 1'b0;
          state_d   = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      S_CAPTURE: begin
        wr_en = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_SWAP;
        end else begin
          row_d    = row_q + 4'd1;
          settle_d = 8'd0;
          state_d  = S_SETTLE;
        end
      end

      S_SWAP: begin
        front_d = ~front_q;
        done    = 1'b1;
        // The queued request is consumed here; a start in this very cycle
        // becomes the new queued request.
        pending_d = start;
        if (pending_q) begin
          row_d    = 4'd0;
          settle_d = 8'd0;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start && (state_q == S_SETTLE || state_q == S_CAPTURE)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= 4'd0;
      settle_q   <= 8'd0;
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      disp_col_q <= 16'd0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          frame_q[b][r] <= 16'd0;
        end
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      settle_q   <= settle_d;
      front_q    <= front_d;
      pending_q  <= pending_d;
      // Read uses the current front, so a swap is seen on the next read.
      disp_col_q <= frame_q[front_q][disp_row];
      if (wr_en) begin
        frame_q[~front_q][row_q] <= grid_col;
      end
    end
  end

  assign grid_row  = {12'd0, row_q};
  assign disp_col  = disp_col_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_grid_frame_sequencer.sv
module tb_grid_frame_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  // default instance
  logic        start, busy, done;
  logic [15:0] grid_row, grid_col, disp_col;
  logic [3:0]  disp_row;
  logic [1:0]  dbg_state;

  // ROWS=4, SETTLE=1 instance
  logic        start2, busy2, done2;
  logic [15:0] grid_row2, grid_col2, disp_col2;
  logic [3:0]  disp_row2;
  logic [1:0]  dbg_state2;

  // mapper models: a lookup of the frame the game logic "wants"
  logic [15:0] tbl  [16];
  logic [15:0] tbl2 [16];
  logic [15:0] vis  [16];   // frame expected to be visible on the default DUT

  assign grid_col  = tbl[grid_row[3:0]];
  assign grid_col2 = tbl2[grid_row2[3:0]];

  grid_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .grid_row(grid_row), .grid_col(grid_col), .disp_row(disp_row),
    .disp_col(disp_col), .dbg_state(dbg_state)
  );

  grid_frame_sequencer #(.ROWS(4), .SETTLE(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .grid_row(grid_row2), .grid_col(grid_col2), .disp_row(disp_row2),
    .disp_col(disp_col2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Read every display row of the default DUT and compare against vis.
  task automatic read_all1();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(vis[k]);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      disp_row = 4'(k);
      @(negedge clk);
      check("disp_col_row", disp_col, exp_q.pop_front());
    end
  endtask

  // One frame on the default DUT. Negedge n is the n-th negedge after the
  // edge that samples start: row r is driven for n = 3r+1..3r+3, done is
  // seen at n = 16*3+1 = 49, and row 5 of the display flips at the second
  // read after done.
  task automatic build1(input logic [15:0] old5, input logic [15:0] new5);
    @(negedge clk);
    disp_row = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 51; n++) begin
      if (n > 1) @(negedge clk);
      check("done",     16'(done), 16'(n == 49));
      check("busy",     16'(busy), 16'(n <= 49));
      check("grid_row", grid_row, (n <= 48) ? 16'((n - 1) / 3) : 16'd15);
      check("tear_row5", disp_col, (n <= 50) ? old5 : new5);
    end
  endtask

  task automatic rand_tbl();
    for (int k = 0; k < 16; k++) tbl[k] = 16'($urandom_range(0, 65535));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ndone;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
    disp_row = 4'd0; disp_row2 = 4'd0;
    for (int k = 0; k < 16; k++) begin
      tbl[k] = 16'd0; tbl2[k] = 16'd0; vis[k] = 16'd0;
    end

    // reset then idle
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy",  16'(busy), 16'd0);
    check("rst_done",  16'(done), 16'd0);
    check("rst_row",   grid_row, 16'd0);
    check("rst_state", 16'(dbg_state), 16'd0);
    check("rst_busy2", 16'(busy2), 16'd0);
    check("rst_row2",  grid_row2, 16'd0);
    read_all1();

    // single frame: diagonal
    for (int k = 0; k < 16; k++) tbl[k] = 16'h8000 >> k;
    build1(vis[5], tbl[5]);
    vis = tbl;
    read_all1();

    // no tearing: frame A all ones, then frame B all zeros
    for (int k = 0; k < 16; k++) tbl[k] = 16'hFFFF;
    build1(vis[5], 16'hFFFF);
    vis = tbl;
    for (int k = 0; k < 16; k++) tbl[k] = 16'h0000;
    build1(16'hFFFF, 16'h0000);
    vis = tbl;
    read_all1();

    // random frames
    for (int f = 0; f < 2; f++) begin
      rand_tbl();
      build1(vis[5], tbl[5]);
      vis = tbl;
      read_all1();
    end

    // start while busy: pulses at n = 0, 10, 20 -> done at 49 and 98
    rand_tbl();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      check("q_done", 16'(done), 16'(n == 49 || n == 98));
      check("q_busy", 16'(busy), 16'(n <= 98));
      if (n == 10 || n == 20) start = 1'b1;
    end
    check("q_ndone", 16'(ndone), 16'd2);
    vis = tbl;
    read_all1();

    // reset mid-build at row 7
    rand_tbl();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);   // now at n = 22
    check("mid_row7", grid_row, 16'd7);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_busy", 16'(busy), 16'd0);
    check("mid_done", 16'(done), 16'd0);
    check("mid_row",  grid_row, 16'd0);
    for (int k = 0; k < 16; k++) vis[k] = 16'd0;
    read_all1();
    rand_tbl();
    build1(16'd0, tbl[5]);
    vis = tbl;
    read_all1();

    // ROWS=4, SETTLE=1: done at 4*2+1 = 9, rows 4..15 stay zero
    for (int k = 0; k < 16; k++) tbl2[k] = 16'($urandom_range(1, 65535));
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      check("s_done", 16'(done2), 16'(n == 9));
      check("s_busy", 16'(busy2), 16'(n <= 9));
      check("s_row",  grid_row2, (n <= 8) ? 16'((n - 1) / 2) : 16'd3);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      disp_row2 = 4'(k);
      @(negedge clk);
      check("s_disp", disp_col2, (k < 4) ? tbl2[k] : 16'd0);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_frame_sequencer.md
# grid_frame_sequencer

Sequences the combinational snake/food grid mapper one row at a time, capturing each 16-bit column pattern into a double-buffered 16×16 frame store. It sits between the game-logic tick and the LED-matrix display driver. A complete frame is built in the back buffer and swapped in atomically, so the display never shows a half-updated snake.

## Interface

Parameters:
- ROWS, 16, number of grid rows scanned per frame (≤ 16).
- SETTLE, 2, wait cycles after changing `grid_row` before sampling `grid_col` (≥ 1). Covers the mapper's long combinational path.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  reset; synchronous, active-low.
- start  input  1  request to build a new frame; single-cycle pulse from the game tick.
- busy  output  1  high while a frame build is in progress.
- done  output  1  one-cycle pulse when the new frame becomes visible.
- grid_row  output  16  row index driven to the mapper, zero-extended from 4 bits.
- grid_col  input  16  mapper result for `grid_row`; bit 15 is column 0.
- disp_row  input  4  row requested by the display driver.
- disp_col  output  16  front-buffer contents of `disp_row`, registered.

## Operation

- Storage:
  - Two 16×16-bit buffers, `buf[0]` and `buf[1]`.
  - 1-bit `front` selects the buffer the display reads; the other buffer is the back buffer.
- State machine states: IDLE, SETTLE, CAPTURE, SWAP.
  - IDLE: `busy`=0. On `start`=1: row counter ← 0, settle counter ← 0, go to SETTLE.
  - SETTLE: `grid_row` = row counter. Increment the settle counter. When it reaches SETTLE−1, go to CAPTURE.
  - CAPTURE: back[row] ← `grid_col`.
    - If row == ROWS−1, go to SWAP.
    - Otherwise, row ← row+1, settle counter ← 0, go to SETTLE.
  - SWAP: `front` ← ~`front`, assert `done` for this one cycle.
    - If `pending`=1, clear it and restart as from IDLE with `start`.
    - Otherwise, go to IDLE.
- `busy` = 1 in SETTLE, CAPTURE and SWAP.
- `start` while busy:
  - Sets a 1-bit `pending` flag.
  - Further starts while `pending` is already set are merged into it; no queue beyond depth 1.
- `start` in the SWAP cycle also sets `pending`.
- Back-buffer rows ≥ ROWS are never written; they keep their reset value of 0.
- In IDLE, `grid_row` holds its last driven value.
- Display read: `disp_col` ← buf[`front`][`disp_row`] every cycle, independent of FSM state.
  - A swap takes effect on the read issued in the cycle after SWAP.
- Reset (`reset_n`=0 at a clk edge) overrides everything, including a build in progress. Afterwards:
  - state IDLE, `busy`=0, `done`=0, `grid_row`=0, `disp_col`=0;
  - `front`=0, `pending`=0, both buffers all-zero.
  - A partially built back buffer is discarded.

## Timing

- Latency from a `start` pulse sampled in IDLE at edge N:
  - SETTLE is entered at N+1.
  - `done` is high during cycle N + ROWS·(SETTLE+1) + 1.
  - With defaults: 16·3+1 = 49 cycles after the start edge.
- Mapper timing:
  - `grid_row` changes at the edge entering SETTLE for that row.
  - `grid_col` is sampled at the end of CAPTURE, which gives SETTLE+1 full cycles of settle time.
- `disp_col` latency: 1 cycle after `disp_row`.
- Pending restart:
  - SETTLE for row 0 begins the cycle after SWAP.
  - Back-to-back frames are spaced ROWS·(SETTLE+1)+1 cycles apart.
- `done` is never high for two consecutive cycles.

## Test plan

- Reset then idle:
  - Stimulus: hold reset_n=0 for 2 cycles, release, read `disp_row`=0..15.
  - Response: `disp_col`=0x0000 for every row, `busy`=0, `done`=0, `grid_row`=0.
- Single frame, defaults:
  - Stimulus: model `grid_col` = 0x8000 >> row for the driven `grid_row`; pulse `start`.
  - Response: `done` exactly 49 cycles later; each `grid_row` value 0..15 is held for 3 cycles; afterwards `disp_row`=k returns 0x8000>>k.
- No tearing:
  - Stimulus: preload frame A (all 0xFFFF), start frame B (all 0x0000); read `disp_row`=5 every cycle during the build.
  - Response: 0xFFFF up to and including the SWAP cycle's read; 0x0000 from the next read on.
- Start while busy:
  - Stimulus: pulse `start` at cycle 0, then again at cycles 10 and 20.
  - Response: exactly two `done` pulses, at cycles 49 and 98; `busy` stays high continuously between them.
- Reset mid-build:
  - Stimulus: assert reset_n=0 at row 7 of a frame.
  - Response: next cycle `busy`=0, all `disp_col` reads 0; a subsequent `start` produces a full clean frame in 49 cycles.
- ROWS=4, SETTLE=1 instance:
  - Stimulus: pulse `start`.
  - Response: `done` after 4·2+1 = 9 cycles; rows 4..15 read back 0x0000.
